// File: rtl/noc_pkg.sv
// Shared oscillator-monitor NoC definitions: flit type codes, field widths and
// the flit-sink FSM state encoding.
package noc_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b00;
  localparam logic [1:0] FLIT_BODY = 2'b01;
  localparam logic [1:0] FLIT_RSVD = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  localparam int ID_W   = 4;
  localparam int OSC_W  = 5;
  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    ST_WAIT_HEAD = 2'd0,
    ST_WAIT_BODY = 2'd1,
    ST_WAIT_TAIL = 2'd2
  } sink_state_e;

endpackage

// File: rtl/noc_flit_sink.sv
// Root-side depacketizer: reassembles HEAD/BODY/TAIL flits into tagged 24-bit
// oscillator records. Optional saturating error counter: FLIT_SINK_ERRCNT_EN.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_WAIT_HEAD | idle, expecting a HEAD that opens a packet
// ST_WAIT_BODY | ID/Osc latched, expecting BODY with count[23:8]
// ST_WAIT_TAIL | count[23:8] latched, expecting TAIL with count[7:0]
module noc_flit_sink
  import noc_pkg::*;
#(
  parameter int NumOsc = 25,
  parameter int NumNI  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              FifoEmpty_i,
  output logic              FifoRd_o,
  input  logic [31:0]       FifoRdData_i,
  output logic              RecValid_o,
  input  logic              RecReady_i,
  output logic [ID_W-1:0]   RecId_o,
  output logic [OSC_W-1:0]  RecOsc_o,
  output logic [DATA_W-1:0] RecData_o,
  output logic              RoundDone_o,
  output logic              ErrPulse_o,
  output logic [7:0]        ErrCnt_o
);

  sink_state_e       r_state;
  logic              r_rd_pend;
  logic [ID_W-1:0]   r_hdr_id;
  logic [OSC_W-1:0]  r_hdr_osc;
  logic [15:0]       r_cnt_hi;
  logic              r_rec_valid;
  logic [ID_W-1:0]   r_rec_id;
  logic [OSC_W-1:0]  r_rec_osc;
  logic [DATA_W-1:0] r_rec_data;
  logic              r_err_pulse;

  logic [1:0]        w_type;
  logic [ID_W-1:0]   w_head_id;
  logic [OSC_W-1:0]  w_head_osc;
  logic              w_head_ok;
  logic              w_accept;
  logic              w_unused;

  assign w_type     = FifoRdData_i[31:30];
  assign w_head_id  = FifoRdData_i[8:5];
  assign w_head_osc = FifoRdData_i[4:0];
  assign w_head_ok  = (int'(w_head_id) < NumNI) && (int'(w_head_osc) < NumOsc);
  assign w_unused   = &{1'b0, FifoRdData_i[29:16]};

  assign w_accept    = r_rec_valid & RecReady_i;
  assign FifoRd_o    = ~FifoEmpty_i & ~(r_rec_valid & ~RecReady_i);
  assign RoundDone_o = w_accept & (r_rec_id == ID_W'(NumNI - 1))
                                & (r_rec_osc == OSC_W'(NumOsc - 1));

  assign RecValid_o = r_rec_valid;
  assign RecId_o    = r_rec_id;
  assign RecOsc_o   = r_rec_osc;
  assign RecData_o  = r_rec_data;
  assign ErrPulse_o = r_err_pulse;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_WAIT_HEAD;
      r_rd_pend   <= 1'b0;
      r_hdr_id    <= '0;
      r_hdr_osc   <= '0;
      r_cnt_hi    <= '0;
      r_rec_valid <= 1'b0;
      r_rec_id    <= '0;
      r_rec_osc   <= '0;
      r_rec_data  <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_rd_pend   <= FifoRd_o;
      r_err_pulse <= 1'b0;

      if (w_accept) begin
        r_rec_valid <= 1'b0;
        r_rec_id    <= '0;
        r_rec_osc   <= '0;
        r_rec_data  <= '0;
      end

      if (r_rd_pend) begin
        // Any in-range HEAD (re)latches the tag; the FSM decides whether it is an error.
        if (w_type == FLIT_HEAD && w_head_ok) begin
          r_hdr_id  <= w_head_id;
          r_hdr_osc <= w_head_osc;
        end

        case (r_state)
          ST_WAIT_HEAD: begin
            if (w_type == FLIT_HEAD && w_head_ok) begin
              r_state <= ST_WAIT_BODY;
            end else begin
              r_err_pulse <= 1'b1;
            end
          end
          ST_WAIT_BODY: begin
            if (w_type == FLIT_BODY) begin
              r_cnt_hi <= FifoRdData_i[15:0];
              r_state  <= ST_WAIT_TAIL;
            end else begin
              r_err_pulse <= 1'b1;
              r_state     <= (w_type == FLIT_HEAD && w_head_ok) ? ST_WAIT_BODY : ST_WAIT_HEAD;
            end
          end
          ST_WAIT_TAIL: begin
            if (w_type == FLIT_TAIL) begin
              r_rec_valid <= 1'b1;
              r_rec_id    <= r_hdr_id;
              r_rec_osc   <= r_hdr_osc;
              r_rec_data  <= {r_cnt_hi, FifoRdData_i[7:0]};
              r_state     <= ST_WAIT_HEAD;
            end else begin
              r_err_pulse <= 1'b1;
              r_state     <= (w_type == FLIT_HEAD && w_head_ok) ? ST_WAIT_BODY : ST_WAIT_HEAD;
            end
          end
          default: r_state <= ST_WAIT_HEAD;
        endcase
      end
    end
  end

`ifdef FLIT_SINK_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_cnt <= '0;
    end else if (r_err_pulse && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign ErrCnt_o = r_err_cnt;
`else
  assign ErrCnt_o = '0;
`endif

endmodule

// File: tb/tb_noc_flit_sink.sv
// Scoreboard bench for noc_flit_sink: a flit-level reference parser predicts
// records and error counts; a monitor checks every accepted record.
module tb_noc_flit_sink;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        FifoEmpty_i = 1'b1;
  logic        FifoRd_o;
  logic [31:0] FifoRdData_i = '0;
  logic        RecValid_o;
  logic        RecReady_i = 1'b0;
  logic [3:0]  RecId_o;
  logic [4:0]  RecOsc_o;
  logic [23:0] RecData_o;
  logic        RoundDone_o;
  logic        ErrPulse_o;
  logic [7:0]  ErrCnt_o;

  noc_flit_sink #(.NumOsc(25), .NumNI(4)) dut (
    .clk(clk), .rstn(rstn),
    .FifoEmpty_i(FifoEmpty_i), .FifoRd_o(FifoRd_o), .FifoRdData_i(FifoRdData_i),
    .RecValid_o(RecValid_o), .RecReady_i(RecReady_i),
    .RecId_o(RecId_o), .RecOsc_o(RecOsc_o), .RecData_o(RecData_o),
    .RoundDone_o(RoundDone_o), .ErrPulse_o(ErrPulse_o), .ErrCnt_o(ErrCnt_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  osc;
    logic [23:0] data;
  } rec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] fifo_q[$];
  rec_t        exp_q[$];
  bit          tail_pop_at[int];
  bit          pop_pend   = 1'b0;
  bit          ready_ctl  = 1'b0;
  bit          rand_ready = 1'b0;

  // Reference parser state: 0 = need HEAD, 1 = need BODY, 2 = need TAIL.
  int          m_stage = 0;
  logic [3:0]  m_id;
  logic [4:0]  m_osc;
  logic [15:0] m_hi;
  int          m_err = 0;
  int          m_round = 0;
  int          err_seen = 0;
  int          round_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic [31:0] f);
    logic [1:0] t;
    bit ok;
    t  = f[31:30];
    ok = (f[8:5] < 4'd4) && (f[4:0] < 5'd25);
    if (t == 2'b00 && ok && m_stage != 0) begin
      m_err++;
      m_id = f[8:5]; m_osc = f[4:0]; m_stage = 1;
    end else if (t == 2'b00 && ok) begin
      m_id = f[8:5]; m_osc = f[4:0]; m_stage = 1;
    end else if (t == 2'b01 && m_stage == 1) begin
      m_hi = f[15:0]; m_stage = 2;
    end else if (t == 2'b11 && m_stage == 2) begin
      exp_q.push_back('{id: m_id, osc: m_osc, data: {m_hi, f[7:0]}});
      if (m_id == 4'd3 && m_osc == 5'd24) m_round++;
      m_stage = 0;
    end else begin
      m_err++;
      m_stage = 0;
    end
  endtask

  task automatic push_flit(input logic [31:0] f);
    model_step(f);
    fifo_q.push_back(f);
  endtask

  task automatic push_pkt(input logic [3:0] id, input logic [4:0] osc, input logic [23:0] d);
    push_flit({2'b00, 21'($urandom), id, osc});
    push_flit({2'b01, 14'($urandom), d[23:8]});
    push_flit({2'b11, 22'($urandom), d[7:0]});
  endtask

  // FIFO model: data for a pop appears in the following cycle.
  initial forever begin
    @(negedge clk);
    if (!rstn) pop_pend = 1'b0;
    else if (pop_pend && fifo_q.size() > 0) FifoRdData_i = fifo_q.pop_front();
    FifoEmpty_i = (fifo_q.size() == 0);
    RecReady_i  = rand_ready ? 1'($urandom_range(0, 1)) : ready_ctl;
    #1;
    pop_pend = rstn && FifoRd_o;
    if (pop_pend && fifo_q[0][31:30] == 2'b11) tail_pop_at[cyc] = 1'b1;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;
  logic [32:0] prev_rec = '0;

  initial forever begin
    @(negedge clk);
    #2;
    if (!rstn) begin
      prev_valid = 1'b0;
    end else begin
      if (RecValid_o && !prev_valid)
        chk("latency_tail_to_valid", 32'(tail_pop_at.exists(cyc - 2)), 32'd1);
      if (RecValid_o && prev_valid && !prev_ready)
        chk("hold_stable", prev_rec[31:0], {RecId_o, RecOsc_o, RecData_o[22:0]} ^ {9'd0, 23'd0});
      if (RecValid_o && !RecReady_i)
        chk("pop_stalled", 32'(FifoRd_o), 32'd0);
      if (ErrPulse_o) err_seen++;
      if (RoundDone_o) round_seen++;
      if (RecValid_o && RecReady_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", 32'd1, 32'd0);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          chk("rec_id", 32'(RecId_o), 32'(e.id));
          chk("rec_osc", 32'(RecOsc_o), 32'(e.osc));
          chk("rec_data", 32'(RecData_o), 32'(e.data));
          chk("round_pulse", 32'(RoundDone_o), (e.id == 4'd3 && e.osc == 5'd24) ? 32'd1 : 32'd0);
        end
      end
      if (!(RecValid_o && RecReady_i) && RoundDone_o)
        chk("round_without_accept", 32'(RoundDone_o), 32'd0);
      prev_valid = RecValid_o;
      prev_ready = RecReady_i;
      prev_rec   = {1'b0, RecId_o, RecOsc_o, RecData_o[22:0]};
    end
  end

  function automatic logic [31:0] exp_errcnt();
`ifdef FLIT_SINK_ERRCNT_EN
    return (m_err > 255) ? 32'd255 : 32'(m_err);
`else
    return 32'd0;
`endif
  endfunction

  task automatic drain(input string nm);
    int n;
    ready_ctl  = 1'b1;
    rand_ready = 1'b0;
    n = 0;
    while ((fifo_q.size() != 0 || pop_pend || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain_in_budget"}, 32'(n < 3000), 32'd1);
    repeat (5) @(negedge clk);
    chk({nm, "_err_pulses"}, 32'(err_seen), 32'(m_err));
    chk({nm, "_err_cnt"}, 32'(ErrCnt_o), exp_errcnt());
    chk({nm, "_round"}, 32'(round_seen), 32'(m_round));
  endtask

  initial begin
    int e0;
    int r;
    #1000000;
    $display("FAIL watchdog: no finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int r;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_fifo_rd", 32'(FifoRd_o), 32'd0);
    chk("rst_valid", 32'(RecValid_o), 32'd0);
    chk("rst_rec", {RecId_o, RecOsc_o, RecData_o[22:0]}, 32'd0);
    chk("rst_data_msb", 32'(RecData_o[23]), 32'd0);
    chk("rst_round", 32'(RoundDone_o), 32'd0);
    chk("rst_err", 32'(ErrPulse_o), 32'd0);
    chk("rst_errcnt", 32'(ErrCnt_o), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Single packet from the reference example.
    ready_ctl = 1'b1;
    push_flit(32'h0000_0023);
    push_flit(32'h4000_ABCD);
    push_flit(32'hC000_00EF);
    chk("model_single_rec", 32'(exp_q.size()), 32'd1);
    drain("single");

    // Backpressure: three packets held off for ten cycles.
    ready_ctl = 1'b0;
    for (int i = 0; i < 3; i++)
      push_pkt(4'($urandom_range(0, 3)), 5'($urandom_range(0, 23)), 24'($urandom));
    repeat (10) @(negedge clk);
    #3;
    chk("bp_rd_low", 32'(FifoRd_o), 32'd0);
    chk("bp_valid", 32'(RecValid_o), 32'd1);
    chk("bp_fifo_kept", 32'(fifo_q.size() > 0), 32'd1);
    drain("backpressure");

    // Protocol errors.
    e0 = m_err;
    push_flit({2'b01, 30'h0000_1234});
    drain("body_first");
    chk("body_first_one_err", 32'(m_err - e0), 32'd1);
    e0 = m_err;
    push_flit({2'b00, 21'd0, 4'd1, 5'd7});
    push_pkt(4'd2, 5'd0, 24'h5A_A55A);
    drain("head_head");
    chk("head_head_one_err", 32'(m_err - e0), 32'd1);
    e0 = m_err;
    push_flit({2'b10, 30'h1555_5555});
    drain("reserved");
    chk("reserved_one_err", 32'(m_err - e0), 32'd1);

    // Out-of-range oscillator index.
    e0 = m_err;
    push_pkt(4'd0, 5'd25, 24'h12_3456);
    drain("range_osc");
    chk("range_three_errs", 32'(m_err - e0), 32'd3);
    e0 = m_err;
    push_pkt(4'd4, 5'd0, 24'h65_4321);
    drain("range_id");

    // Full round with random backpressure.
    r = m_round;
    rand_ready = 1'b1;
    for (int id = 0; id < 4; id++)
      for (int osc = 0; osc < 25; osc++)
        push_pkt(4'(id), 5'(osc), 24'($urandom));
    drain("round");
    chk("round_one_pulse", 32'(m_round - r), 32'd1);

    // Random mix of clean packets, junk flits and out-of-range heads.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)
        push_flit($urandom);
      else if (r < 18)
        push_pkt(4'($urandom_range(4, 15)), 5'($urandom_range(25, 31)), 24'($urandom));
      else
        push_pkt(4'($urandom_range(0, 3)), 5'($urandom_range(0, 23)), 24'($urandom));
    end
    drain("random");

    // Reset mid-packet: partial packet and error history are dropped.
    push_flit({2'b00, 21'd0, 4'd1, 5'd1});
    push_flit({2'b01, 14'd0, 16'hBEEF});
    drain("pre_reset");
    rstn = 1'b0;
    m_stage = 0;
    m_err = 0;
    err_seen = 0;
    repeat (2) @(negedge clk);
    #3;
    chk("reset_errcnt", 32'(ErrCnt_o), 32'd0);
    chk("reset_valid", 32'(RecValid_o), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    push_pkt(4'd2, 5'd9, 24'hC0_FFEE);
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
